// File: rtl/prim_sel_sched_if.sv
// Requester / decoder / downstream bundle for the primitive-select scheduler.
interface prim_sel_sched_if #(
  parameter int N_REQ = 19,
  parameter int W_CTL = 32,
  parameter int IW    = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] sel_prim;
  logic [W_CTL-1:0] prim_out;
  logic [W_CTL-1:0] ctl_word;
  logic             ctl_valid;
  logic             ctl_ready;
  logic [IW-1:0]    ctl_src;
  logic             busy;

  modport master (
    output req, prim_out, ctl_ready,
    input  gnt, sel_prim, ctl_word,
    input  ctl_valid, ctl_src, busy
  );

  modport slave (
    input  req, prim_out, ctl_ready,
    output gnt, sel_prim, ctl_word,
    output ctl_valid, ctl_src, busy
  );
endinterface

// File: rtl/prim_sel_sched.sv
// Round-robin scheduler sharing one sel_prim -> prim_out decoder
// among N_REQ requesters; issues the settled word via valid/ready.
module prim_sel_sched #(
  parameter int N_REQ  = 19,
  parameter int W_CTL  = 32,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst,
  prim_sel_sched_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE, SELECT, SETTLE_W, ISSUE
  } state_t;

  state_t           r_state, w_state;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic [W_CTL-1:0] r_word, w_word;
  logic             r_valid, w_valid;
  logic [IW-1:0]    r_src, w_src;
  logic [IW-1:0]    r_ptr, w_ptr;
  logic [3:0]       r_cnt, w_cnt;

  logic             w_found;
  logic [IW-1:0]    w_k;

  // Descending scan so the lowest offset from r_ptr is written last.
  always_comb begin
    logic [IW:0] v_s;
    v_s     = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      v_s = {1'b0, r_ptr} + (IW+1)'(i);
      if (v_s >= (IW+1)'(N_REQ))
        v_s = v_s - (IW+1)'(N_REQ);
      if (bus.req[v_s[IW-1:0]]) begin
        w_found = 1'b1;
        w_k     = v_s[IW-1:0];
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_word  = r_word;
    w_valid = r_valid;
    w_src   = r_src;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state = SELECT;
          w_gnt   = N_REQ'(1) << w_k;
          w_src   = w_k;
          w_ptr   = (w_k == IW'(N_REQ-1)) ? '0 : w_k + 1'b1;
        end
      end
      SELECT: begin
        w_cnt   = 4'(SETTLE - 1);
        w_state = SETTLE_W;
      end
      SETTLE_W: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_word  = bus.prim_out;
          w_valid = 1'b1;
          w_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_valid && bus.ctl_ready) begin
          w_valid = 1'b0;
          if (w_found) begin
            w_state = SELECT;
            w_gnt   = N_REQ'(1) << w_k;
            w_src   = w_k;
            w_ptr   = (w_k == IW'(N_REQ-1)) ? '0 : w_k + 1'b1;
          end else begin
            w_state = IDLE;
            w_gnt   = '0;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_gnt   <= w_gnt;
      r_word  <= w_word;
      r_valid <= w_valid;
      r_src   <= w_src;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
    end
  end

  // Grant and decoder select are the same one-hot register.
  assign bus.gnt       = r_gnt;
  assign bus.sel_prim  = r_gnt;
  assign bus.ctl_word  = r_word;
  assign bus.ctl_valid = r_valid;
  assign bus.ctl_src   = r_src;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_prim_sel_sched.sv
// Directed bench for prim_sel_sched with a behavioural decoder model.
module tb_prim_sel_sched;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  prim_sel_sched_if #(.N_REQ(19), .W_CTL(32)) bus ();

  prim_sel_sched #(
    .N_REQ(19), .W_CTL(32), .SETTLE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dec(input int k);
    return 32'hC0DE_0000 + 32'(k << 8) + 32'(k);
  endfunction

  always_comb begin
    bus.prim_out = 32'hDEAD_BEEF;
    for (int i = 0; i < 19; i++)
      if (bus.sel_prim[i]) bus.prim_out = dec(i);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
    chk({tag, "_sel"}, 32'(bus.sel_prim), 32'h0);
    chk({tag, "_word"}, bus.ctl_word, 32'h0);
    chk({tag, "_vld"}, 32'(bus.ctl_valid), 32'h0);
    chk({tag, "_src"}, 32'(bus.ctl_src), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic grant_chk(input string tag, input int k);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << k);
    chk({tag, "_sel"}, 32'(bus.sel_prim), 32'(1) << k);
    chk({tag, "_src"}, 32'(bus.ctl_src), 32'(k));
    chk({tag, "_vlo"}, 32'(bus.ctl_valid), 32'h0);
  endtask

  task automatic issue_chk(input string tag, input int k);
    chk({tag, "_vld"}, 32'(bus.ctl_valid), 32'h1);
    chk({tag, "_word"}, bus.ctl_word, dec(k));
    chk({tag, "_src"}, 32'(bus.ctl_src), 32'(k));
  endtask

  initial begin
    int k;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.ctl_ready = 1'b0;
    step();
    step();
    chk_zero("reset");

    // single request, index 4
    rst     = 1'b0;
    bus.req = 19'h00010;
    step();
    grant_chk("single", 4);
    chk("single_busy", 32'(bus.busy), 32'h1);
    bus.req = '0;
    step();
    step();
    chk("single_early", 32'(bus.ctl_valid), 32'h0);
    step();
    issue_chk("single", 4);
    bus.ctl_ready = 1'b1;
    step();
    chk("single_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("single_idle_sel", 32'(bus.sel_prim), 32'h0);
    chk("single_idle_vld", 32'(bus.ctl_valid), 32'h0);
    chk("single_idle_busy", 32'(bus.busy), 32'h0);

    // all requesting, back-to-back with wrap
    rst = 1'b1;
    step();
    rst     = 1'b0;
    bus.req = 19'h7FFFF;
    for (int n = 0; n < 20; n++) begin
      k = n % 19;
      step();
      grant_chk("rr", k);
      step();
      step();
      chk("rr_early", 32'(bus.ctl_valid), 32'h0);
      step();
      issue_chk("rr", k);
      if (n == 19) bus.req = '0;
    end
    step();
    chk("rr_idle_busy", 32'(bus.busy), 32'h0);
    chk("rr_idle_vld", 32'(bus.ctl_valid), 32'h0);

    // ptr is 1: request 18 and 0
    bus.req = 19'h40001;
    step();
    grant_chk("wrap_a", 18);
    step();
    step();
    step();
    issue_chk("wrap_a", 18);
    step();
    grant_chk("wrap_b", 0);
    bus.req = '0;
    step();
    step();
    step();
    issue_chk("wrap_b", 0);
    step();
    chk("wrap_idle", 32'(bus.busy), 32'h0);

    // backpressure, ptr is 1
    bus.ctl_ready = 1'b0;
    bus.req       = 19'h00008;
    step();
    grant_chk("bp", 3);
    step();
    step();
    step();
    issue_chk("bp", 3);
    bus.req = 19'h00208;
    for (int n = 0; n < 10; n++) begin
      step();
      issue_chk("bp_hold", 3);
      chk("bp_hold_gnt", 32'(bus.gnt), 32'h8);
      chk("bp_hold_sel", 32'(bus.sel_prim), 32'h8);
    end
    bus.ctl_ready = 1'b1;
    step();
    grant_chk("bp_next", 9);
    bus.req       = '0;
    bus.ctl_ready = 1'b0;
    step();
    step();
    step();
    issue_chk("bp_next", 9);
    bus.ctl_ready = 1'b1;
    step();
    chk("bp_idle", 32'(bus.busy), 32'h0);

    // one-cycle pulse on req[7], ptr is 10
    bus.ctl_ready = 1'b0;
    bus.req       = 19'h00080;
    step();
    bus.req = '0;
    grant_chk("pulse", 7);
    step();
    step();
    step();
    issue_chk("pulse", 7);
    bus.ctl_ready = 1'b1;
    step();
    chk("pulse_idle", 32'(bus.busy), 32'h0);
    bus.ctl_ready = 1'b0;

    // reset during SETTLE_W
    bus.req = 19'h00004;
    step();
    grant_chk("rst_sw", 2);
    step();
    rst     = 1'b1;
    bus.req = '0;
    step();
    chk_zero("rst_sw");
    rst     = 1'b0;

    // reset during ISSUE
    bus.req = 19'h00020;
    step();
    grant_chk("rst_is", 5);
    bus.req = '0;
    step();
    step();
    step();
    issue_chk("rst_is", 5);
    rst = 1'b1;
    step();
    chk_zero("rst_is");
    rst     = 1'b0;
    bus.req = 19'h00100;
    step();
    grant_chk("post_rst", 8);
    bus.req = '0;
    step();
    step();
    step();
    issue_chk("post_rst", 8);

    // pointer returns to 0 after reset
    rst = 1'b1;
    step();
    rst     = 1'b0;
    bus.req = 19'h00101;
    step();
    grant_chk("ptr0", 0);
    bus.req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prim_sel_sched.md
Name: prim_sel_sched

Overview:
- Round-robin scheduler that shares the primitive-select decoder between 19 requesters.
- Picks one pending requester and drives the decoder's one-hot `sel_prim` input.
- Waits a fixed settle time, then captures the decoder's 32-bit `prim_out` control word and issues it downstream with a valid/ready handshake.
- Sits between the requesting units and the combinational `sel_prim` -> `prim_out` decoder.

Parameters:
- N_REQ, 19, number of requesters; equals `sel_prim` width.
- W_CTL, 32, width of the decoder control word.
- SETTLE, 2, cycles `sel_prim` is held stable before `prim_out` is sampled; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- gnt  output  N_REQ  one-hot grant; held from grant until handshake completes.
- sel_prim  output  N_REQ  one-hot select to decoder; all-zero when not selecting.
- prim_out  input  W_CTL  combinational control word returned by the decoder.
- ctl_word  output  W_CTL  registered control word issued downstream.
- ctl_valid  output  1  `ctl_word` valid.
- ctl_ready  input  1  downstream accepts `ctl_word` when `ctl_valid` && `ctl_ready`.
- ctl_src  output  5  index (0..18) of the requester that owns `ctl_word`.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values, applied at any clock edge with `rst`=1, including mid-operation:
  - state = IDLE; `gnt`, `sel_prim`, `ctl_word` = 0; `ctl_src` = 0; `ctl_valid` = 0; `busy` = 0.
  - Round-robin pointer `ptr` = 0; settle counter = 0.
  - An in-flight word is dropped; no handshake is owed after reset.
- States: IDLE, SELECT, SETTLE_W, ISSUE.
- IDLE: if any `req` bit is set, arbitrate and go to SELECT next cycle; otherwise stay.
- Arbitration:
  - Search `req` starting at index `ptr`, ascending, wrapping 18 -> 0.
  - The first set bit k wins.
  - `gnt` and `sel_prim` become one-hot bit k on entry to SELECT.
  - `ctl_src` = k; `ptr` = (k+1) mod N_REQ, so after k=18 the pointer is 0.
- SELECT: load settle counter with SETTLE-1, go to SETTLE_W.
- SETTLE_W:
  - While the counter is nonzero, decrement it.
  - When it is 0, register `ctl_word` <= `prim_out`, set `ctl_valid`=1, go to ISSUE.
  - Latency from grant-visible cycle to `ctl_valid` = SETTLE+1 cycles (3 at default).
- ISSUE:
  - Hold `ctl_word`, `ctl_src`, `gnt`, `sel_prim` and `ctl_valid` stable until `ctl_valid` && `ctl_ready`.
  - On a handshake cycle with any `req` pending (the granted requester excluded), arbitrate immediately and go straight to SELECT; `ctl_valid` drops to 0 in that edge (back-to-back, no IDLE bubble).
  - On a handshake with nothing pending, clear `gnt`/`sel_prim`/`ctl_valid` and go to IDLE.
- Request withdrawal: requests are sampled only at arbitration. Deasserting `req[k]` after grant does not abort the cycle; the word is still issued.
- The granted requester holding `req` high through handshake is not re-granted in the same arbitration when others are pending. The pointer rule already guarantees this; with no others pending it is re-granted.
- `sel_prim` is never multi-hot. It is all-zero in IDLE and during reset.
- `ctl_ready` high while `ctl_valid`=0 has no effect.
- `busy` = (state != IDLE).

Test Plan:
- Reset then `req`=19'h00010 -> `gnt`=`sel_prim`=19'h00010 one cycle later.
  - `ctl_valid`=1 three cycles after grant, with `ctl_word` equal to decoder `prim_out` for that select and `ctl_src`=4.
  - `ctl_ready`=1 -> IDLE, `gnt`=0, `busy`=0.
- `req`=19'h7FFFF held, `ctl_ready`=1 -> grants in order 0,1,2,...,18,0 with no IDLE cycles.
  - Each `ctl_valid` pulse lasts 1 cycle.
  - `ptr` wraps after index 18.
- `req`=19'h40001 with `ptr`=1 -> index 18 granted first, then 0; `ctl_src` sequence 18, 0.
- Backpressure: `ctl_ready`=0 for 10 cycles in ISSUE -> `ctl_word`, `ctl_src`, `gnt` and `sel_prim` stay constant.
  - A new `req` bit during the stall is not granted until the handshake completes.
- `req[7]` pulsed for 1 cycle only -> full cycle still completes and word issued with `ctl_src`=7.
- `rst` asserted in SETTLE_W and again in ISSUE -> next cycle all outputs 0, `ptr`=0.
  - After release with `req`=19'h00100, index 8 is granted.
